// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
// Holds the requester count, select/counter widths and the pick function.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [SEL_W-1:0] idx
  );
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan ptr+1, ptr+2, ptr+3, ptr; masked bits never win.
  function automatic pick_t rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [SEL_W-1:0]   ptr,
    input logic [NUM_REQ-1:0] exclude
  );
    logic [SEL_W-1:0] i;
    rr_pick = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = ptr + SEL_W'(k);
      if (!rr_pick.found && req[i] && !exclude[i]) begin
        rr_pick.found = 1'b1;
        rr_pick.idx   = i;
      end
    end
  endfunction

endpackage

// File: rtl/mux4_bus.sv
// Plain WIDTH-bit 4:1 multiplexer used as the arbiter's shared data path.
// Purely combinational.
module mux4_bus
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four requesters with bounded burst hold.
// Drives the mux select and one-hot grant, and registers the chosen beat.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   d0,
  input  logic [WIDTH-1:0]   d1,
  input  logic [WIDTH-1:0]   d2,
  input  logic [WIDTH-1:0]   d3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   dout,
  output logic               dvalid,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [SEL_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   y;
  logic               owned;
  logic               beat;
  logic               others;
  logic               drop;
  logic               rel;
  logic               arb;
  logic [NUM_REQ-1:0] excl;
  pick_t              pick;

  mux4_bus #(
    .WIDTH (WIDTH)
  ) u_bus (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (sel),
    .y   (y)
  );

  always_comb begin
    owned  = |gnt;
    beat   = gnt[sel] & req[sel];
    others = |(req & ~onehot(sel));
    drop   = owned & ~req[sel];
    rel    = drop | (owned & (cnt == CNT_MAX) & others);
    arb    = ~owned | rel;
    excl   = drop ? onehot(sel) : '0;
    pick   = rr_pick(req, ptr, excl);
  end

  assign busy = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      sel    <= '0;
      ptr    <= 2'd3;
      cnt    <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
    end else begin
      dvalid <= beat;
      if (beat) begin
        dout <= y;
      end
      if (arb) begin
        if (pick.found) begin
          gnt <= onehot(pick.idx);
          sel <= pick.idx;
          ptr <= pick.idx;
          cnt <= '0;
        end else begin
          gnt <= '0;
        end
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (hold 4 and hold 1) share stimulus
// and are compared each cycle against an owner/queue-style reference model.
module tb_mux4_rr_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0][7:0]  d;
  logic [1:0][3:0]  gnt;
  logic [1:0][1:0]  sel;
  logic [1:0][7:0]  dout;
  logic [1:0]       dvalid;
  logic [1:0]       busy;

  int checks   = 0;
  int failures = 0;

  int   hold_lim[2] = '{4, 1};
  int   own[2];
  int   last[2];
  int   msel[2];
  int   held[2];
  int   waitc[2][4];
  int   mdout[2];
  int   mdv[2];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .gnt(gnt[0]), .sel(sel[0]), .dout(dout[0]),
    .dvalid(dvalid[0]), .busy(busy[0])
  );

  mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .gnt(gnt[1]), .sel(sel[1]), .dout(dout[1]),
    .dvalid(dvalid[1]), .busy(busy[1])
  );

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      own[m]   = -1;
      last[m]  = 3;
      msel[m]  = 0;
      held[m]  = 0;
      mdout[m] = 0;
      mdv[m]   = 0;
      for (int i = 0; i < 4; i++) waitc[m][i] = 0;
    end
  endtask

  // Reference: who owns the bus, how long it has held, who won last.
  task automatic model_edge();
    int o, w, excl, idx;
    bit others, arb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      o = own[m];
      if (o >= 0 && req[o]) begin
        mdout[m] = d[o];
        mdv[m]   = 1;
      end else begin
        mdv[m] = 0;
      end
      others = 0;
      for (int i = 0; i < 4; i++)
        if (req[i] && i != o) others = 1;
      arb = (o < 0) || !req[o] || (held[m] >= hold_lim[m] && others);
      if (arb) begin
        excl = (o >= 0 && !req[o]) ? o : -1;
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          idx = (last[m] + k) % 4;
          if (w < 0 && req[idx] && idx != excl) w = idx;
        end
        if (w >= 0) begin
          own[m]  = w;
          last[m] = w;
          msel[m] = w;
          held[m] = 1;
        end else begin
          own[m] = -1;
        end
      end else begin
        held[m]++;
      end
    end
  endtask

  task automatic compare();
    int eg;
    string p;
    for (int m = 0; m < 2; m++) begin
      p  = $sformatf("h%0d_", hold_lim[m]);
      eg = (own[m] < 0) ? 0 : (1 << own[m]);
      check({p, "gnt"},    int'(gnt[m]),    eg);
      check({p, "sel"},    int'(sel[m]),    msel[m]);
      check({p, "dout"},   int'(dout[m]),   mdout[m]);
      check({p, "dvalid"}, int'(dvalid[m]), mdv[m]);
      check({p, "busy"},   int'(busy[m]),   int'(eg != 0));
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !gnt[m][i]) waitc[m][i]++;
        else waitc[m][i] = 0;
        check({p, "wait_bound"},
              int'(waitc[m][i] <= 3 * hold_lim[m] + 1), 1);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    d     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare();
    check("rst_ptr_prio", int'(sel[0]), 0);
    rst_n = 1'b1;

    // single requester 2 with fixed data
    req  = 4'b0100;
    d[2] = 8'hA5;
    step();
    check("r2_gnt", int'(gnt[0]), 4'b0100);
    check("r2_sel", int'(sel[0]), 2);
    repeat (3) step();
    check("r2_dout", int'(dout[0]), 8'hA5);
    req = '0;
    repeat (2) step();

    // all four requesting
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      rand_data();
      step();
    end
    req = '0;
    step();

    // requester 1 alone, never rotates
    req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      rand_data();
      step();
    end
    check("r1_hold_gnt", int'(gnt[0]), 4'b0010);

    // owner 3 drops as requester 0 rises
    req = 4'b1000;
    repeat (3) step();
    check("own3_gnt", int'(gnt[0]), 4'b1000);
    req = 4'b0001;
    step();
    check("wrap_gnt_h4", int'(gnt[0]), 4'b0001);
    check("wrap_gnt_h1", int'(gnt[1]), 4'b0001);

    // random traffic
    req = '0;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) req[i] = ~req[i];
      rand_data();
      step();
    end

    // asynchronous reset during a burst
    req = 4'b0010;
    repeat (4) step();
    check("pre_rst_gnt", int'(gnt[0]), 4'b0010);
    check("pre_rst_dv",  int'(dvalid[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("async_gnt",  int'(gnt[m]),    0);
      check("async_dv",   int'(dvalid[m]), 0);
      check("async_busy", int'(busy[m]),   0);
    end
    model_reset();
    step();
    rst_n = 1'b1;
    req   = 4'b0011;
    step();
    check("post_rst_first", int'(gnt[0]), 4'b0001);
    step();

    // hold-1 rotation between requesters 1 and 3
    req = 4'b1010;
    for (int k = 0; k < 10; k++) begin
      rand_data();
      step();
    end
    req = '0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
